// File: rtl/rr_arbiter.sv
// Round-robin arbiter with registered one-hot grants, optional locking and bounded hold.
// Latency: req sampled at edge k drives gnt from edge k; owner handover takes one edge with no idle gap.
// Backpressure: a locked owner keeps the grant while req stays high, up to MAX_HOLD cycles when nonzero.
module rr_arbiter #(
  parameter int N        = 8,
  parameter int W        = 3,
  parameter int LOCK     = 1,
  parameter int MAX_HOLD = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt,
  output logic [W-1:0] gnt_id,
  output logic         gnt_valid,
  output logic         gnt_preempt
);

  localparam logic IDLE  = 1'b0;
  localparam logic GRANT = 1'b1;

  // With unlimited hold the counter only needs to saturate somewhere.
  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD + 1) : ((MAX_HOLD == 1) ? 1 : 4);
  localparam logic [HW-1:0] HMAX = HW'(MAX_HOLD);
  localparam logic [N-1:0]  ONE  = {{(N-1){1'b0}}, 1'b1};
  localparam logic [W-1:0]  LAST = W'(N - 1);
  localparam logic [W:0]    NW   = (W+1)'(N);

  logic          st, st_n;
  logic [W-1:0]  ptr, ptr_n, ptr_inc;
  logic [W-1:0]  own_n, start, win;
  logic          found, rearb, pre_n;
  logic [HW-1:0] hcnt, hcnt_n;
  logic [N-1:0]  gnt_n;

  // Returns {found, index}; the rotated vector puts candidate s at bit 0.
  function automatic logic [W:0] search(input logic [N-1:0] r, input logic [W-1:0] s);
    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    logic [W:0]     sum;
    logic [W:0]     res;
    dbl = {r, r} >> s;
    rot = dbl[N-1:0];
    res = '0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, s} + (W+1)'(k);
      if (sum >= NW) sum = sum - NW;
      if (!res[W] && rot[k]) res = {1'b1, sum[W-1:0]};
    end
    return res;
  endfunction

  always_comb begin
    ptr_inc = (gnt_id == LAST) ? '0 : gnt_id + 1'b1;
    st_n    = st;
    ptr_n   = ptr;
    own_n   = gnt_id;
    hcnt_n  = hcnt;
    pre_n   = 1'b0;
    rearb   = 1'b0;
    start   = ptr;

    if (st == GRANT) begin
      if (LOCK == 0 || !(|(req & gnt))) begin
        rearb = 1'b1;
      end else if (MAX_HOLD != 0 && hcnt == HMAX) begin
        rearb = 1'b1;
        pre_n = 1'b1;
      end else if (hcnt != '1) begin
        hcnt_n = hcnt + 1'b1;
      end
    end

    // Searching from owner+1 leaves the current owner as the last candidate.
    if (rearb) begin
      ptr_n = ptr_inc;
      start = ptr_inc;
    end

    {found, win} = search(req, start);

    if (st == IDLE || rearb) begin
      if (found) begin
        st_n   = GRANT;
        own_n  = win;
        hcnt_n = HW'(1);
      end else begin
        st_n   = IDLE;
        own_n  = '0;
        hcnt_n = '0;
        pre_n  = 1'b0;
      end
    end

    gnt_n = (st_n == GRANT) ? (ONE << own_n) : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st          <= IDLE;
      ptr         <= '0;
      hcnt        <= '0;
      gnt         <= '0;
      gnt_id      <= '0;
      gnt_preempt <= 1'b0;
    end else begin
      st          <= st_n;
      ptr         <= ptr_n;
      hcnt        <= hcnt_n;
      gnt         <= gnt_n;
      gnt_id      <= own_n;
      gnt_preempt <= pre_n;
    end
  end

  assign gnt_valid = (st == GRANT);

`ifndef SYNTHESIS
  a_onehot : assert property (@(posedge clk) disable iff (rst) $onehot0(gnt));
  a_valid  : assert property (@(posedge clk) disable iff (rst) gnt_valid == (|gnt));
  a_id     : assert property (@(posedge clk) disable iff (rst) !gnt_valid || gnt == (ONE << gnt_id));
`endif

endmodule

// File: tb/tb_rr_arbiter.sv
// Directed bench: lock/handover table, LOCK=0 rotation, N=5 wrap, and MAX_HOLD preemption.
module tb_rr_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [7:0] req_lock, req_rot, req_pre;
  logic [4:0] req_wrap;

  logic [7:0] gnt_lock, gnt_rot, gnt_pre;
  logic [4:0] gnt_wrap;
  logic [2:0] id_lock, id_rot, id_pre, id_wrap;
  logic       vld_lock, vld_rot, vld_pre, vld_wrap;
  logic       pre_lock, pre_rot, pre_pre, pre_wrap;

  int checks = 0;
  int errors = 0;

  rr_arbiter #(.N(8), .W(3), .LOCK(1), .MAX_HOLD(0)) u_lock (
    .clk(clk), .rst(rst), .req(req_lock), .gnt(gnt_lock), .gnt_id(id_lock),
    .gnt_valid(vld_lock), .gnt_preempt(pre_lock));

  rr_arbiter #(.N(8), .W(3), .LOCK(0), .MAX_HOLD(0)) u_rot (
    .clk(clk), .rst(rst), .req(req_rot), .gnt(gnt_rot), .gnt_id(id_rot),
    .gnt_valid(vld_rot), .gnt_preempt(pre_rot));

  rr_arbiter #(.N(8), .W(3), .LOCK(1), .MAX_HOLD(3)) u_pre (
    .clk(clk), .rst(rst), .req(req_pre), .gnt(gnt_pre), .gnt_id(id_pre),
    .gnt_valid(vld_pre), .gnt_preempt(pre_pre));

  rr_arbiter #(.N(5), .W(3), .LOCK(0), .MAX_HOLD(0)) u_wrap (
    .clk(clk), .rst(rst), .req(req_wrap), .gnt(gnt_wrap), .gnt_id(id_wrap),
    .gnt_valid(vld_wrap), .gnt_preempt(pre_wrap));

  typedef struct packed {
    logic       rst;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] id;
    logic       vld;
    logic       pre;
  } vec_t;

  localparam int NV = 22;
  vec_t tbl [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int         rot_id  [10];
  logic [2:0] pid     [17];
  logic       ppre    [17];
  logic [7:0] one8;
  logic [4:0] one5;

  initial begin
    rst      = 1'b1;
    req_lock = '0;
    req_rot  = '0;
    req_pre  = '0;
    req_wrap = '0;
    one8     = 8'h01;
    one5     = 5'h01;

    //          rst   req    gnt    id  vld pre
    tbl[0]  = '{1'b1, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 8'h24, 8'h04, 3'd2, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 8'h24, 8'h04, 3'd2, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 8'h24, 8'h04, 3'd2, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 8'h20, 8'h20, 3'd5, 1'b1, 1'b0};
    tbl[11] = '{1'b0, 8'h20, 8'h20, 3'd5, 1'b1, 1'b0};
    tbl[12] = '{1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 8'hA0, 8'h80, 3'd7, 1'b1, 1'b0};
    tbl[14] = '{1'b0, 8'hA0, 8'h80, 3'd7, 1'b1, 1'b0};
    tbl[15] = '{1'b0, 8'h20, 8'h20, 3'd5, 1'b1, 1'b0};
    tbl[16] = '{1'b0, 8'hFF, 8'h20, 3'd5, 1'b1, 1'b0};
    tbl[17] = '{1'b1, 8'hFF, 8'h00, 3'd0, 1'b0, 1'b0};
    tbl[18] = '{1'b0, 8'hA0, 8'h20, 3'd5, 1'b1, 1'b0};
    tbl[19] = '{1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0};
    tbl[20] = '{1'b0, 8'h01, 8'h01, 3'd0, 1'b1, 1'b0};
    tbl[21] = '{1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0};

    rot_id = '{0, 1, 2, 3, 4, 5, 6, 7, 0, 1};

    // req=0x82 for 10 cycles, then 0x02 alone for 7 cycles
    pid  = '{3'd1, 3'd1, 3'd1, 3'd7, 3'd7, 3'd7, 3'd1, 3'd1, 3'd1, 3'd7,
             3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1};
    ppre = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1,
             1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

    for (int i = 0; i < NV; i++) begin
      rst      = tbl[i].rst;
      req_lock = tbl[i].req;
      step();
      chk($sformatf("lock[%0d].gnt", i), 32'(gnt_lock), 32'(tbl[i].gnt));
      chk($sformatf("lock[%0d].id", i),  32'(id_lock),  32'(tbl[i].id));
      chk($sformatf("lock[%0d].vld", i), 32'(vld_lock), 32'(tbl[i].vld));
      chk($sformatf("lock[%0d].pre", i), 32'(pre_lock), 32'(tbl[i].pre));
    end

    rst      = 1'b1;
    req_lock = '0;
    step();
    chk("rot.reset_vld", 32'(vld_rot), 32'd0);
    chk("wrap.reset_gnt", 32'(gnt_wrap), 32'd0);
    rst      = 1'b0;
    req_rot  = 8'hFF;
    req_wrap = 5'b10001;
    for (int i = 0; i < 10; i++) begin
      step();
      chk($sformatf("rot[%0d].id", i),  32'(id_rot),  32'(rot_id[i]));
      chk($sformatf("rot[%0d].vld", i), 32'(vld_rot), 32'd1);
      chk($sformatf("rot[%0d].gnt", i), 32'(gnt_rot), 32'(one8 << rot_id[i]));
      chk($sformatf("wrap[%0d].id", i), 32'(id_wrap), (i % 2 == 1) ? 32'd4 : 32'd0);
      chk($sformatf("wrap[%0d].gnt", i), 32'(gnt_wrap),
          32'(one5 << ((i % 2 == 1) ? 4 : 0)));
    end
    req_rot  = '0;
    req_wrap = '0;
    step();
    chk("rot.idle_gnt", 32'(gnt_rot), 32'd0);
    chk("wrap.idle_vld", 32'(vld_wrap), 32'd0);

    rst = 1'b1;
    step();
    chk("pre.reset_pre", 32'(pre_pre), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 17; i++) begin
      req_pre = (i < 10) ? 8'h82 : 8'h02;
      step();
      chk($sformatf("pre[%0d].id", i),  32'(id_pre),  32'(pid[i]));
      chk($sformatf("pre[%0d].pre", i), 32'(pre_pre), 32'(ppre[i]));
      chk($sformatf("pre[%0d].gnt", i), 32'(gnt_pre), 32'(one8 << pid[i]));
      chk($sformatf("pre[%0d].vld", i), 32'(vld_pre), 32'd1);
    end
    req_pre = '0;
    step();
    chk("pre.idle_gnt", 32'(gnt_pre), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
